// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: start bit, LSB-first data, optional even parity, one stop bit.
// Bit timing comes from an external bit timer; define UART_TX_PARITY_EN to add the parity bit.
module uart_tx_ctrl #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 tick,
    output logic                 tmr_reset,
    output logic                 tmr_enable,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, shift_nxt;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 tmr_reset_q, tmr_reset_d;
    logic                 tmr_enable_q, tmr_enable_d;
    logic                 advance;

`ifdef UART_TX_PARITY_EN
    logic parity_q, parity_d;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] word);
        return ^word;
    endfunction
`endif

    // The timer is held in reset for one cycle after every advance, so a tick
    // still showing from the previous bit period can never count twice.
    assign advance   = tick && !tmr_reset_q;
    assign shift_nxt = shift_q >> 1;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        tx_d         = tx_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        tmr_reset_d  = 1'b0;
        tmr_enable_d = tmr_enable_q;
`ifdef UART_TX_PARITY_EN
        parity_d     = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d         = 1'b1;
                busy_d       = 1'b0;
                tmr_reset_d  = 1'b1;
                tmr_enable_d = 1'b0;
                if (start) begin
                    state_d      = S_START;
                    shift_d      = din;
                    cnt_d        = '0;
                    tx_d         = 1'b0;
                    busy_d       = 1'b1;
                    tmr_enable_d = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d     = even_parity(din);
`endif
                end
            end
            S_START: begin
                if (advance) begin
                    state_d     = S_DATA;
                    tx_d        = shift_q[0];
                    cnt_d       = '0;
                    tmr_reset_d = 1'b1;
                end
            end
            S_DATA: begin
                if (advance) begin
                    tmr_reset_d = 1'b1;
                    if (cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        shift_d = shift_nxt;
                        tx_d    = shift_nxt[0];
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (advance) begin
                    state_d     = S_STOP;
                    tx_d        = 1'b1;
                    tmr_reset_d = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (advance) begin
                    state_d      = S_IDLE;
                    tx_d         = 1'b1;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    tmr_reset_d  = 1'b1;
                    tmr_enable_d = 1'b0;
                end
            end
            default: begin
                state_d      = S_IDLE;
                tx_d         = 1'b1;
                busy_d       = 1'b0;
                tmr_reset_d  = 1'b1;
                tmr_enable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            tmr_reset_q  <= 1'b1;
            tmr_enable_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            tmr_reset_q  <= tmr_reset_d;
            tmr_enable_q <= tmr_enable_d;
`ifdef UART_TX_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign tmr_reset  = tmr_reset_q;
    assign tmr_enable = tmr_enable_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a behavioural bit timer (tick when count > k_thr).
// Follows the UART_TX_PARITY_EN build of the design when that macro is defined.
module tb_uart_tx_ctrl;

    localparam int DATA_BITS = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = DATA_BITS + 3;
    localparam logic [7:0] D_FIRST = 8'h07;
`else
    localparam int NBITS = DATA_BITS + 2;
    localparam logic [7:0] D_FIRST = 8'hA5;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] din;
    logic       tick;
    logic       tmr_reset;
    logic       tmr_enable;
    logic       tx;
    logic       busy;
    logic       done;

    int k_thr;
    int tcnt = 0;
    int n_chk = 0;
    int n_pass = 0;

    uart_tx_ctrl #(.DATA_BITS(DATA_BITS)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .din        (din),
        .tick       (tick),
        .tmr_reset  (tmr_reset),
        .tmr_enable (tmr_enable),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Bit timer model: cleared while in reset, counts while enabled.
    always @(posedge clk) begin
        if (tmr_reset)
            tcnt <= 0;
        else if (tmr_enable)
            tcnt <= tcnt + 1;
    end
    assign tick = (tcnt > k_thr) && !tmr_reset;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Expected line level for frame bit i: start, LSB-first data, [parity], stop.
    function automatic logic frame_bit(input logic [7:0] d, input int i);
        if (i == 0)
            return 1'b0;
        if (i <= DATA_BITS)
            return d[i-1];
`ifdef UART_TX_PARITY_EN
        if (i == DATA_BITS + 1)
            return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic kick(input logic [7:0] d);
        @(negedge clk);
        start = 1'b1;
        din   = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        din   = ~d;
    endtask

    // Called just after the edge that accepted the word; checks every cycle of
    // the frame and the done cycle. poke >= 0 pulses start with din=FF mid-frame.
    task automatic check_frame(input logic [7:0] d, input int poke, input string name);
        int bad;
        int per;
        per = k_thr + 3;
        for (int b = 0; b < NBITS; b++) begin
            bad = 0;
            for (int c = 0; c < per; c++) begin
                @(negedge clk);
                if (tx !== frame_bit(d, b)) bad++;
                if (busy !== 1'b1 || done !== 1'b0 || tmr_enable !== 1'b1) bad++;
                if (tmr_reset !== (c == 0)) bad++;
                if (poke >= 0) begin
                    if (b * per + c == poke) begin
                        start = 1'b1;
                        din   = 8'hFF;
                    end else if (b * per + c == poke + 1) begin
                        start = 1'b0;
                        din   = 8'h00;
                    end
                end
            end
            chk($sformatf("%s bit%0d errors", name, b), bad, 0);
        end
        @(negedge clk);
        chk({name, " done"}, int'(done), 1);
        chk({name, " busy at done"}, int'(busy), 0);
        chk({name, " tx at done"}, int'(tx), 1);
        chk({name, " tmr_reset at done"}, int'(tmr_reset), 1);
        chk({name, " tmr_enable at done"}, int'(tmr_enable), 0);
    endtask

    task automatic check_idle(input int cycles, input string name);
        int bad;
        bad = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
            if (tmr_reset !== 1'b1 || tmr_enable !== 1'b0) bad++;
        end
        chk({name, " idle errors"}, bad, 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        din   = 8'h00;
        k_thr = 2500;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        chk("reset tx", int'(tx), 1);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset tmr_reset", int'(tmr_reset), 1);
        chk("reset tmr_enable", int'(tmr_enable), 0);
        check_idle(100, "post-reset");

        // Full-rate frame; a start with din=FF lands in the middle of it.
        kick(D_FIRST);
        check_frame(D_FIRST, 3000, "frame1");
        check_idle(30, "after frame1");

        // Shorter bit period for the remaining scenarios.
        k_thr = 20;

        // Reset during data bit 3 (frame bit index 4); 0xC3 has bit3 = 0.
        kick(8'hC3);
        repeat (4 * (k_thr + 3) + 5) @(negedge clk);
        chk("pre-reset tx data bit3", int'(tx), 0);
        chk("pre-reset busy", int'(busy), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mid-frame reset tx", int'(tx), 1);
        chk("mid-frame reset busy", int'(busy), 0);
        chk("mid-frame reset tmr_reset", int'(tmr_reset), 1);
        chk("mid-frame reset tmr_enable", int'(tmr_enable), 0);
        chk("mid-frame reset done", int'(done), 0);
        check_idle(10, "after reset");

        kick(8'h96);
        check_frame(8'h96, -1, "clean");
        check_idle(5, "after clean");

        // start held high: frames run back to back, next start bit right after done.
        @(negedge clk);
        start = 1'b1;
        din   = 8'h00;
        @(posedge clk);
        #1;
        check_frame(8'h00, -1, "b2b0");
        check_frame(8'h00, -1, "b2b1");
        start = 1'b0;
        check_idle(30, "after b2b");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
